// File: rtl/apb_pkg.sv
// Shared types and width helpers for the APB memory slave.
// Holds the transfer FSM state enum and derived-width functions.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Number of byte-offset bits inside one data word.
    function automatic int off_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Number of bits needed to index a word array of the given depth.
    function automatic int idx_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Byte-strobed word storage, cleared asynchronously by preset.
// Ports: pclk, preset, we, strb, idx, wdata in; rdata out (comb).
module apb_mem_array
    import apb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int IDX_W  = idx_bits(DEPTH),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              we,
    input  logic [STRB_W-1:0] strb,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (strb[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave with a small byte-strobed memory and programmable waits.
// Ports: APB pclk/preset/psel/penable/pwrite/paddr/pwdata/pstrb,
// wait_cfg in; prdata, pready, pslverr out.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16,
    parameter int WAIT_W = 4
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    input  logic [WAIT_W-1:0]   wait_cfg,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int OFF_W = off_bits(DATA_W);
    localparam int IDX_W = idx_bits(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK =
        ADDR_W'((1 << OFF_W) - 1);
    // One extra bit so DEPTH never truncates in the range compare.
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    state_t            state_n;
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] cnt_n;

    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              err;
    logic              we;
    logic [DATA_W-1:0] rdata;

    assign word_idx = paddr >> OFF_W;
    assign mem_idx  = IDX_W'(word_idx);
    assign err      = ((paddr & OFF_MASK) != '0) ||
                      ({1'b0, word_idx} >= DEPTH_A);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                // psel with penable here is a protocol violation: ignored.
                if (psel && !penable) begin
                    state_n = ACCESS;
                    cnt_n   = wait_cfg;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (penable) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        we      = 1'b0;
        if (state == ACCESS) begin
            pready  = (cnt == '0);
            pslverr = pready && err;
            if (!pwrite && !err) begin
                prdata = rdata;
            end
            we = psel && penable && pready && pwrite && !err;
        end
    end

    apb_mem_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .pclk  (pclk),
        .preset(preset),
        .we    (we),
        .strb  (pstrb),
        .idx   (mem_idx),
        .wdata (pwdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: driver queues expected
// responses, a negedge monitor pops and compares on completion.
module tb_apb_mem_slave;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int DP = 16;
    localparam int WW = 4;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [DW/8-1:0] pstrb = '0;
    logic [WW-1:0] wait_cfg = '0;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start = 0;
    int   c0;
    exp_t exp_q[$];
    exp_t me;

    apb_mem_slave #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .DEPTH (DP),
        .WAIT_W(WW)
    ) dut (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .wait_cfg(wait_cfg),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: all sampling on the falling edge.
    always @(negedge pclk) begin
        cyc = cyc + 1;
        if (!preset && psel && !penable) begin
            start = cyc;
            chk("setup_pready", {31'b0, pready}, 32'h0);
            chk("setup_prdata", prdata, 32'h0);
        end
        if (!preset && psel && penable && pready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_completion", 32'h1, 32'h0);
            end else begin
                me = exp_q.pop_front();
                chk("prdata", prdata, me.rd);
                chk("pslverr", {31'b0, pslverr}, {31'b0, me.err});
                chk("cycles", 32'(cyc - start + 1), 32'(me.cyc));
            end
        end
    end

    task automatic xfer(input logic wr, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [3:0] w, input logic [31:0] erd,
                        input logic eerr);
        exp_t e;
        int   n;
        e.rd  = erd;
        e.err = eerr;
        e.cyc = int'(w) + 2;
        exp_q.push_back(e);
        psel     = 1'b1;
        penable  = 1'b0;
        pwrite   = wr;
        paddr    = a;
        pwdata   = d;
        pstrb    = s;
        wait_cfg = w;
        @(posedge pclk); #1;
        penable = 1'b1;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!pready && n < 40);
        if (!pready) chk("pready_timeout", 32'h0, 32'h1);
        @(posedge pclk); #1;
    endtask

    task automatic idle();
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1);
    end

    initial begin
        #3;
        chk("rst_pready", {31'b0, pready}, 32'h0);
        chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;

        xfer(1, 8'h04, 32'hDEADBEEF, 4'hF, 4'd0, 32'h0, 0);
        xfer(0, 8'h04, 32'h0, 4'h0, 4'd0, 32'hDEADBEEF, 0);
        idle();
        xfer(0, 8'h04, 32'h0, 4'h0, 4'd3, 32'hDEADBEEF, 0);
        idle();

        xfer(1, 8'h08, 32'hAAAAAAAA, 4'hF, 4'd0, 32'h0, 0);
        xfer(1, 8'h08, 32'h11223344, 4'h5, 4'd1, 32'h0, 0);
        xfer(0, 8'h08, 32'h0, 4'h0, 4'd0, 32'hAA22AA44, 0);
        idle();

        xfer(1, 8'h40, 32'hFFFFFFFF, 4'hF, 4'd0, 32'h0, 1);
        xfer(0, 8'h40, 32'h0, 4'h0, 4'd0, 32'h0, 1);
        xfer(0, 8'h06, 32'h0, 4'h0, 4'd0, 32'h0, 1);
        xfer(1, 8'h06, 32'hFFFFFFFF, 4'hF, 4'd2, 32'h0, 1);
        xfer(1, 8'h04, 32'h12345678, 4'h0, 4'd0, 32'h0, 0);
        xfer(0, 8'h04, 32'h0, 4'h0, 4'd0, 32'hDEADBEEF, 0);
        xfer(0, 8'h08, 32'h0, 4'h0, 4'd0, 32'hAA22AA44, 0);
        xfer(0, 8'h00, 32'h0, 4'h0, 4'd0, 32'h0, 0);
        idle();

        c0 = cyc;
        xfer(1, 8'h00, 32'h01010101, 4'hF, 4'd0, 32'h0, 0);
        xfer(1, 8'h04, 32'h02020202, 4'hF, 4'd0, 32'h0, 0);
        xfer(1, 8'h08, 32'h03030303, 4'hF, 4'd0, 32'h0, 0);
        xfer(1, 8'h0C, 32'h04040404, 4'hF, 4'd0, 32'h0, 0);
        chk("b2b_cycles", 32'(cyc - c0), 32'd8);
        penable  = 1'b0;
        pwrite   = 1'b1;
        paddr    = 8'h00;
        pwdata   = 32'hFFFFFFFF;
        pstrb    = 4'hF;
        wait_cfg = 4'd2;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        idle();
        xfer(0, 8'h00, 32'h0, 4'h0, 4'd0, 32'h01010101, 0);
        xfer(0, 8'h04, 32'h0, 4'h0, 4'd0, 32'h02020202, 0);
        xfer(0, 8'h08, 32'h0, 4'h0, 4'd0, 32'h03030303, 0);
        xfer(0, 8'h0C, 32'h0, 4'h0, 4'd0, 32'h04040404, 0);
        idle();

        psel     = 1'b1;
        penable  = 1'b0;
        pwrite   = 1'b1;
        paddr    = 8'h0C;
        pwdata   = 32'hFFFFFFFF;
        pstrb    = 4'hF;
        wait_cfg = 4'd3;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        preset = 1'b1;
        #1;
        chk("wrst_pready", {31'b0, pready}, 32'h0);
        chk("wrst_pslverr", {31'b0, pslverr}, 32'h0);
        chk("wrst_prdata", prdata, 32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;
        xfer(0, 8'h0C, 32'h0, 4'h0, 4'd0, 32'h0, 0);
        xfer(0, 8'h04, 32'h0, 4'h0, 4'd0, 32'h0, 0);
        xfer(1, 8'h04, 32'h5A5A5A5A, 4'hF, 4'd0, 32'h0, 0);
        idle();

        psel     = 1'b1;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = 8'h04;
        wait_cfg = 4'd0;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1;
        chk("pre_rst_pready", {31'b0, pready}, 32'h1);
        chk("pre_rst_prdata", prdata, 32'h5A5A5A5A);
        #1;
        preset = 1'b1;
        #1;
        chk("rrst_pready", {31'b0, pready}, 32'h0);
        chk("rrst_prdata", prdata, 32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;
        xfer(0, 8'h04, 32'h0, 4'h0, 4'd0, 32'h0, 0);

        repeat (3) idle();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, pwdata/prdata width (8, 16 or 32).
REQ-002 SHALL have parameter ADDR_W, default 8, paddr width (byte address).
REQ-003 SHALL have parameter DEPTH, default 16, number of DATA_W-bit words.
REQ-004 SHALL have parameter WAIT_W, default 4, wait_cfg width.
REQ-005 SHALL have port pclk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port preset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port psel  input  1  slave select.
REQ-008 SHALL have port penable  input  1  access phase.
REQ-009 SHALL have port pwrite  input  1  1 = write, 0 = read.
REQ-010 SHALL have port paddr  input  ADDR_W  byte address.
REQ-011 SHALL have port pwdata  input  DATA_W  write data.
REQ-012 SHALL have port pstrb  input  DATA_W/8  byte write strobes.
REQ-013 SHALL have port wait_cfg  input  WAIT_W  wait states per transfer, sampled at setup.
REQ-014 SHALL have port prdata  output  DATA_W  read data.
REQ-015 SHALL have port pready  output  1  transfer completes this cycle.
REQ-016 SHALL have port pslverr  output  1  error response, valid only with pready.

Function
REQ-017 SHALL implement FSM states IDLE and ACCESS; state and wait counter registered.
REQ-018 In IDLE, an edge with psel=1 and penable=0 SHALL move to ACCESS and load the counter with wait_cfg.
REQ-019 In IDLE, psel=1 with penable=1 (protocol violation) SHALL be ignored; stay IDLE.
REQ-020 In ACCESS, pready SHALL be 1 exactly when the counter is 0; each edge with counter non-zero SHALL decrement it.
REQ-021 In ACCESS, an edge with psel=1, penable=1 and pready=1 SHALL complete the transfer and return to IDLE.
REQ-022 In ACCESS, psel=0 (abort) SHALL return to IDLE with no memory write.
REQ-023 pready and pslverr SHALL be 0 in IDLE.
REQ-024 Word index SHALL be paddr >> log2(DATA_W/8); the low offset bits are the byte offset.
REQ-025 A non-zero byte offset, or index >= DEPTH, SHALL be an error: pslverr=1 while pready=1, no write, prdata=0.
REQ-026 A write SHALL commit on the completing edge, updating only the bytes whose pstrb bit is 1; pstrb=0 is a legal no-op.
REQ-027 prdata SHALL equal mem[index] while in ACCESS with pwrite=0 and no error, and 0 otherwise.
REQ-028 With wait_cfg=0, every transfer SHALL take exactly 2 cycles (setup + access); with wait_cfg=N, it SHALL take N+2.
REQ-029 Back-to-back transfers (a new setup on the cycle after completion) SHALL be accepted with no idle cycle.

Reset
REQ-030 preset SHALL immediately force state IDLE, counter 0, pready 0, pslverr 0, prdata 0, and all memory words 0.
REQ-031 preset asserted mid-transfer SHALL abort it; no partial write SHALL occur.

Structure
REQ-032 Package apb_pkg SHALL hold the state enum (IDLE, ACCESS) and the derived-width helper functions (byte-offset bits, index bits).
REQ-033 The byte-strobed storage array SHALL be a sub-module, apb_mem_array (DATA_W, DEPTH; write enable, strobes, index, read data).

Verification
REQ-034 Write 0xDEADBEEF to 0x04 (pstrb=0xF, wait_cfg=0), then read 0x04 -> each transfer 2 cycles; prdata=0xDEADBEEF; pslverr=0.
REQ-035 wait_cfg=3, read 0x04 -> pready low for 3 ACCESS cycles, high on the 4th; transfer takes 5 cycles total.
REQ-036 Write 0x11223344 to 0x08 with pstrb=0x5 over 0xAAAAAAAA -> read returns 0xAA22AA44.
REQ-037 Access 0x40 (index 16) and misaligned 0x06 -> pready=1 with pslverr=1, prdata=0, memory unchanged.
REQ-038 Assert preset during a wait-state write to 0x0C -> outputs 0 immediately; a later read of 0x0C returns 0.
REQ-039 Run four back-to-back writes to 0x00, 0x04, 0x08, 0x0C, then psel drop in ACCESS -> all four stored, 8 cycles total; the aborted transfer writes nothing.
